seq_pattern_gen: RTL and testbench

Serial pattern transmitter. Drives a bit stream into the team's serial sequence detectors, such as the 3-bit 101 Moore detectors. On a start request it latches a programmable pattern, length, repeat count and inter-frame gap. It then shifts the pattern out MSB-first, one bit per clock, with Moore-style registered outputs. It serves as the stimulus source on the detector side of the serial data line.

---
 rtl/seq_gen_pkg.sv | 22 ++
 rtl/seq_piso.sv | 43 ++++
 rtl/seq_pattern_gen.sv | 190 +++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// +----------------------------------------------------------------------+
// | seq_gen_pkg                                                          |
// | Shared state encoding and default detector test pattern.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] PAT_101     = 3'b101;
  localparam int         PAT_101_LEN = 3;

endpackage

`default_nettype wire

// File: rtl/seq_piso.sv
// +----------------------------------------------------------------------+
// | seq_piso                                                             |
// | Parallel-in serial-out shift register, MSB first, zero fill.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[W-1];

endmodule

`default_nettype wire

// File: rtl/seq_pattern_gen.sv
// +----------------------------------------------------------------------+
// | seq_pattern_gen                                                      |
// | Serial pattern transmitter with repeat and inter-frame gap control.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [CNT_W-1:0] gap,
  output logic             data,
  output logic             data_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(PAT_W);

  // Left-align the used bits so the shifter's MSB is always pattern[len-1]
  // and every bit below the frame is zero, keeping the line low afterwards.
  function automatic logic [PAT_W-1:0] align_msb(input logic [PAT_W-1:0] p,
                                                 input logic [LEN_W-1:0] l);
    logic [PAT_W-1:0] keep;
    keep = {PAT_W{1'b1}} >> (PAT_W - int'(l));
    return (p & keep) << (PAT_W - int'(l));
  endfunction

  state_t           state_q,   state_d;
  logic [PAT_W-1:0] pat_q,     pat_d;
  logic [LEN_W-1:0] len_q,     len_d;
  logic [CNT_W-1:0] rep_q,     rep_d;
  logic [CNT_W-1:0] gap_q,     gap_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             valid_q,   valid_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             err_q,     err_d;

  logic             w_len_ok;
  logic             w_load;
  logic             w_shift;
  logic [PAT_W-1:0] w_load_val;
  logic             w_msb;

  assign w_len_ok = (len != '0) && (len <= c_max_len);

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    len_d      = len_q;
    rep_d      = rep_q;
    gap_d      = gap_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_load_val = pat_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (w_len_ok) begin
            pat_d      = align_msb(pattern, len);
            len_d      = len;
            rep_d      = repeat_n;
            gap_d      = gap;
            bit_cnt_d  = len - 1'b1;
            w_load     = 1'b1;
            w_load_val = align_msb(pattern, len);
            valid_d    = 1'b1;
            busy_d     = 1'b1;
            state_d    = SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SEND: begin
        if (bit_cnt_q != '0) begin
          w_shift   = 1'b1;
          bit_cnt_d = bit_cnt_q - 1'b1;
        end else if (rep_q != '0) begin
          rep_d = rep_q - 1'b1;
          if (gap_q != '0) begin
            w_shift   = 1'b1;
            gap_cnt_d = gap_q;
            valid_d   = 1'b0;
            state_d   = GAP;
          end else begin
            w_load    = 1'b1;
            bit_cnt_d = len_q - 1'b1;
          end
        end else begin
          w_shift = 1'b1;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      GAP: begin
        if (gap_cnt_q == CNT_W'(1)) begin
          w_load    = 1'b1;
          bit_cnt_d = len_q - 1'b1;
          valid_d   = 1'b1;
          state_d   = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  seq_piso #(
    .W (PAT_W)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .shift (w_shift),
    .din   (w_load_val),
    .msb   (w_msb)
  );

  assign data       = w_msb;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
// +----------------------------------------------------------------------+
// | tb_seq_pattern_gen                                                   |
// | Scoreboard bench: per-cycle expected outputs queued by stimulus.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seq_pattern_gen;
  import seq_gen_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] repeat_n = '0;
  logic [3:0] gap = '0;
  logic       data, data_valid, busy, done, err;

  int         n_checks = 0;
  int         n_fail = 0;
  string      tname = "reset";
  logic [4:0] exp_q[$];
  logic [4:0] m_exp;
  logic [4:0] m_act;

  logic       det_clr = 1'b1;
  logic [1:0] det_st;
  int         det_cnt;

  seq_pattern_gen #(
    .PAT_W (8),
    .LEN_W (4),
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .len        (len),
    .repeat_n   (repeat_n),
    .gap        (gap),
    .data       (data),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Expected vector bits: {data, data_valid, busy, done, err}
  function automatic logic [4:0] enc(input byte c);
    case (c)
      "1":     return 5'b11100;
      "0":     return 5'b01100;
      "g":     return 5'b00100;
      "D":     return 5'b00010;
      "E":     return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(enc(s[i]));
  endtask

  // Monitor: one queued expectation per clock, sampled after the edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      m_exp = exp_q.pop_front();
      m_act = {data, data_valid, busy, done, err};
      n_checks++;
      if (m_act !== m_exp) begin
        n_fail++;
        $display("FAIL %s: d/v/b/dn/e got %b want %b (%0d left)",
                 tname, m_act, m_exp, exp_q.size());
      end
    end
  end

  // Non-overlapping 101 Moore detector fed from the serial line
  always @(posedge clk) begin
    if (det_clr) begin
      det_st  <= 2'd0;
      det_cnt <= 0;
    end else begin
      if (det_st == 2'd3) det_cnt <= det_cnt + 1;
      case (det_st)
        2'd0:    if (data_valid) det_st <= data ? 2'd1 : 2'd0;
        2'd1:    if (data_valid) det_st <= data ? 2'd1 : 2'd2;
        2'd2:    if (data_valid) det_st <= data ? 2'd3 : 2'd0;
        default: det_st <= (data_valid && data) ? 2'd1 : 2'd0;
      endcase
    end
  end

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: timeout, %0d expectations left, want 0", tname, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic start_cfg(input logic [7:0] p, input logic [3:0] l,
                           input logic [3:0] r, input logic [3:0] g, input string e);
    @(negedge clk);
    pattern  = p;
    len      = l;
    repeat_n = r;
    gap      = g;
    start    = 1'b1;
    push_str(e);
    @(negedge clk);
    start    = 1'b0;
    pattern  = ~p;
    repeat_n = ~r;
    gap      = ~g;
  endtask

  task automatic run(input string n, input logic [7:0] p, input logic [3:0] l,
                     input logic [3:0] r, input logic [3:0] g, input string e);
    tname = n;
    start_cfg(p, l, r, g, e);
    wait_drain(e.len() + 8);
  endtask

  initial begin
    logic [7:0] p101;
    p101 = {5'b0, PAT_101};

    @(posedge clk);
    #1;
    n_checks++;
    if ({data, data_valid, busy, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 00000", {data, data_valid, busy, done, err});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run("basic101", p101, 4'(PAT_101_LEN), 4'd0, 4'd0, "101D.");
    run("rep2_gap2", p101, 4'd3, 4'd2, 4'd2, "101gg101gg101D.");

    det_clr = 1'b0;
    run("rep2_gap0", p101, 4'd3, 4'd2, 4'd0, "101101101D..");
    n_checks++;
    if (det_cnt != 3) begin
      n_fail++;
      $display("FAIL detector_hits: got %0d want 3", det_cnt);
    end
    det_clr = 1'b1;

    // Starts while busy and in DONE, with a different pattern, are ignored
    tname = "start_while_busy";
    start_cfg(p101, 4'd3, 4'd0, 4'd0, "101D...");
    @(negedge clk);
    pattern = 8'hFF; len = 4'd8; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_drain(12);

    run("err_len0", 8'h5A, 4'd0, 4'd0, 4'd0, "E..");
    run("err_len9", 8'h5A, 4'd9, 4'd0, 4'd0, "E..");
    run("a5_len8", 8'hA5, 4'd8, 4'd0, 4'd0, "10100101D.");
    run("zeros_len8", 8'h00, 4'd8, 4'd0, 4'd0, "00000000D.");
    run("len1_rep15", 8'hFF, 4'd1, 4'd15, 4'd0, "1111111111111111D.");
    run("ones_gap1", 8'hFF, 4'd8, 4'd1, 4'd1, "11111111g11111111D.");
    run("high_bits_masked", 8'hF2, 4'd3, 4'd0, 4'd3, "010D.");

    // Asynchronous reset between edges, mid-frame
    tname = "async_reset";
    start_cfg(8'hA5, 4'd8, 4'd0, 4'd0, "1010");
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if ({data, data_valid, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: d/v/b got %b want 000", {data, data_valid, busy});
    end
    @(negedge clk);
    rst = 1'b1;
    tname = "post_reset_idle";
    push_str("....");
    wait_drain(10);
    run("after_reset", p101, 4'd3, 4'd0, 4'd0, "101D.");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
